// File: rtl/tqvp_fpu_cmd_frontend.sv
// tqvp_fpu_cmd_frontend: bus-side command stage of the TinyQV FPU peripheral.
// Captures operands/opcodes from register writes into a command FIFO, issues
// them one at a time to the FPU core (valid/ready), holds the result for
// readback, accumulates sticky IEEE flags and drives the interrupt.
// Optional feature: define FPU_FE_TIMEOUT_EN to enable the core response
// timeout (RESULT forced to qNaN, NV and sticky TO set after TO_CYC cycles).
module tqvp_fpu_cmd_frontend #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_op,
    output logic [31:0] cmd_a,
    output logic [31:0] cmd_b,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    input  logic [4:0]  res_flags
);

    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    localparam logic [3:0] A_OPA    = 4'd0;
    localparam logic [3:0] A_OPB    = 4'd1;
    localparam logic [3:0] A_CMD    = 4'd2;
    localparam logic [3:0] A_RESULT = 4'd3;
    localparam logic [3:0] A_STATUS = 4'd4;
    localparam logic [3:0] A_FLAGS  = 4'd5;
    localparam logic [3:0] A_IRQEN  = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Bus decode
    logic [3:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wmask;

    // Software-visible registers
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        irq_en_q;
    logic [31:0] data_out_q;
    logic        data_ready_q;
    logic [31:0] rdata;

    // Command FIFO
    logic [67:0]   fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [4:0]    count_q;
    logic [4:0]    count_d;
    logic          ovf_q;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [67:0]   head;

    // Issue FSM and result side
    state_e      state_q;
    logic        cmd_valid_q;
    logic [3:0]  cmd_op_q;
    logic [31:0] cmd_a_q;
    logic [31:0] cmd_b_q;
    logic [31:0] result_q;
    logic        res_full_q;
    logic [4:0]  flags_q;
    logic [4:0]  flags_clr;
    logic        to_flag;

`ifdef FPU_FE_TIMEOUT_EN
    logic       to_q;
    logic [7:0] to_cnt_q;
    logic       unused_ok;
    assign unused_ok = ^address[1:0];
    assign to_flag   = to_q;
`else
    logic       unused_ok;
    assign unused_ok = ^{address[1:0], TO_CYC};
    assign to_flag   = 1'b0;
`endif

    assign reg_sel = address[5:2];
    assign wr_en   = (data_write_n != 2'b11);
    assign rd_en   = (data_read_n != 2'b11);

    // Byte lanes affected by the current write width
    always_comb begin
        case (data_write_n)
            2'b00:   wmask = 32'h0000_00FF;
            2'b01:   wmask = 32'h0000_FFFF;
            default: wmask = 32'hFFFF_FFFF;
        endcase
    end

    assign push      = wr_en && (reg_sel == A_CMD);
    assign push_ok   = push && (count_q != DEPTH_C);
    assign pop       = (state_q == S_ISSUE) && cmd_valid_q && cmd_ready;
    assign head      = fifo_q[rd_ptr_q];
    assign flags_clr = (wr_en && (reg_sel == A_FLAGS)) ? data_in[4:0] : 5'b0;

    // Occupancy next-state: simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Read data multiplexer
    always_comb begin
        rdata = '0;
        case (reg_sel)
            A_OPA:    rdata = opa_q;
            A_OPB:    rdata = opb_q;
            A_RESULT: rdata = result_q;
            A_STATUS: rdata = {21'b0, count_q, to_flag, ovf_q,
                               (state_q != S_IDLE), res_full_q, 2'b00};
            A_FLAGS:  rdata = {27'b0, flags_q};
            A_IRQEN:  rdata = {31'b0, irq_en_q};
            default:  rdata = '0;
        endcase
    end

    // Operand / IRQ_EN registers and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q        <= '0;
            opb_q        <= '0;
            irq_en_q     <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == A_OPA)) opa_q <= (opa_q & ~wmask) | (data_in & wmask);
            if (wr_en && (reg_sel == A_OPB)) opb_q <= (opb_q & ~wmask) | (data_in & wmask);
            if (wr_en && (reg_sel == A_IRQEN)) irq_en_q <= data_in[0];
            data_ready_q <= rd_en;
            if (rd_en) data_out_q <= rdata;
        end
    end

    // Command FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= {data_in[3:0], opa_q, opb_q};
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (reg_sel == A_STATUS) && data_in[4]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Issue FSM with registered command outputs, result capture and flag accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_a_q     <= '0;
            cmd_b_q     <= '0;
            result_q    <= '0;
            res_full_q  <= 1'b0;
            flags_q     <= '0;
`ifdef FPU_FE_TIMEOUT_EN
            to_q        <= 1'b0;
            to_cnt_q    <= '0;
`endif
        end else begin
            // Software clears first; a same-cycle hardware set below takes priority
            if (rd_en && (reg_sel == A_RESULT)) res_full_q <= 1'b0;
            flags_q <= flags_q & ~flags_clr;
`ifdef FPU_FE_TIMEOUT_EN
            if (wr_en && (reg_sel == A_STATUS) && data_in[5]) to_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if ((count_q != 5'd0) && !res_full_q) begin
                        state_q     <= S_ISSUE;
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= head[67:64];
                        cmd_a_q     <= head[63:32];
                        cmd_b_q     <= head[31:0];
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= S_WAIT;
`ifdef FPU_FE_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        result_q   <= res_data;
                        res_full_q <= 1'b1;
                        flags_q    <= (flags_q & ~flags_clr) | res_flags;
                        state_q    <= S_IDLE;
`ifdef FPU_FE_TIMEOUT_EN
                    end else if (to_cnt_q == 8'(TO_CYC - 1)) begin
                        result_q   <= QNAN;
                        res_full_q <= 1'b1;
                        flags_q    <= (flags_q & ~flags_clr) | 5'b10000;
                        to_q       <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        to_cnt_q   <= to_cnt_q + 8'd1;
`endif
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef FPU_FE_TIMEOUT_EN
    logic unused_qnan;
    assign unused_qnan = ^QNAN;
`endif

    assign data_out       = data_out_q;
    assign data_ready     = data_ready_q;
    assign user_interrupt = irq_en_q & res_full_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_op         = cmd_op_q;
    assign cmd_a          = cmd_a_q;
    assign cmd_b          = cmd_b_q;

endmodule

// File: tb/tb_tqvp_fpu_cmd_frontend.sv
// Directed self-checking bench for tqvp_fpu_cmd_frontend.
module tb_tqvp_fpu_cmd_frontend;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tqvp_fpu_cmd_frontend #(.DEPTH(DEPTH), .TO_CYC(255)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        @(negedge clk);
        address = a; data_in = d; data_write_n = wn;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic read_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a; data_read_n = 2'b00;
        @(negedge clk);
        data_read_n = 2'b11;
        chk({tag, "_rdy"}, {31'b0, data_ready}, 32'd1);
        chk(tag, data_out, exp);
    endtask

    task automatic wait_cmd_valid();
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid === 1'b1) break;
            @(negedge clk);
        end
        chk("cmd_valid_wait", {31'b0, cmd_valid}, 32'd1);
    endtask

    task automatic handshake();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic core_resp(input logic [31:0] d, input logic [4:0] f);
        res_valid = 1'b1; res_data = d; res_flags = f;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] r, input logic [4:0] f);
        bus_write(6'h08, {28'b0, op}, 2'b10);
        wait_cmd_valid();
        chk("do_op_opcode", {28'b0, cmd_op}, {28'b0, op});
        handshake();
        core_resp(r, f);
    endtask

    initial begin
        rst_n = 1'b0; address = '0; data_in = '0; data_write_n = 2'b11;
        data_read_n = 2'b11; cmd_ready = 1'b0; res_valid = 1'b0;
        res_data = '0; res_flags = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
        chk("rst_data_ready", {31'b0, data_ready}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_irq", {31'b0, user_interrupt}, 32'd0);
        chk("rst_cmd_a", cmd_a, 32'd0);
        rst_n = 1'b1;
        read_chk("rst_status", 6'h10, 32'h0);

        // Basic add, issue latency, result readback
        bus_write(6'h00, 32'h3F80_0000, 2'b10);
        bus_write(6'h04, 32'h4000_0000, 2'b10);
        bus_write(6'h08, 32'h0, 2'b10);
        chk("lat_n1", {31'b0, cmd_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n2", {31'b0, cmd_valid}, 32'd1);
        chk("t1_op", {28'b0, cmd_op}, 32'd0);
        chk("t1_a", cmd_a, 32'h3F80_0000);
        chk("t1_b", cmd_b, 32'h4000_0000);
        handshake();
        chk("t1_valid_drop", {31'b0, cmd_valid}, 32'd0);
        read_chk("t1_status_wait", 6'h10, 32'h0000_0008);
        core_resp(32'h4040_0000, 5'b0);
        read_chk("t1_status_full", 6'h10, 32'h0000_0004);
        read_chk("t1_result", 6'h0C, 32'h4040_0000);
        read_chk("t1_status_clr", 6'h10, 32'h0);
        read_chk("t1_flags", 6'h14, 32'h0);

        // Overflow with stalled core, then in-order drain
        for (int i = 1; i <= DEPTH + 1; i++) begin
            bus_write(6'h00, 32'(i), 2'b10);
            bus_write(6'h08, 32'(i), 2'b10);
        end
        read_chk("t2_status_ovf", 6'h10, 32'h0000_0118);
        for (int i = 1; i <= DEPTH; i++) begin
            wait_cmd_valid();
            chk("t2_order_op", {28'b0, cmd_op}, 32'(i));
            chk("t2_order_a", cmd_a, 32'(i));
            handshake();
            core_resp(32'h100 + 32'(i), 5'b0);
            read_chk("t2_result", 6'h0C, 32'h100 + 32'(i));
        end
        repeat (5) @(negedge clk);
        chk("t2_no_extra_issue", {31'b0, cmd_valid}, 32'd0);
        read_chk("t2_status_drained", 6'h10, 32'h0000_0010);
        bus_write(6'h10, 32'h10, 2'b10);
        read_chk("t2_ovf_w1c", 6'h10, 32'h0);

        // Issue blocked while a result is unread
        do_op(4'd9, 32'hABCD_0001, 5'b0);
        bus_write(6'h08, 32'h3, 2'b10);
        repeat (4) @(negedge clk);
        chk("gate_no_issue", {31'b0, cmd_valid}, 32'd0);
        read_chk("gate_status", 6'h10, 32'h0000_0044);
        read_chk("gate_result", 6'h0C, 32'hABCD_0001);
        wait_cmd_valid();
        chk("gate_op", {28'b0, cmd_op}, 32'd3);
        handshake();
        core_resp(32'h0000_0033, 5'b0);
        read_chk("gate_result2", 6'h0C, 32'h0000_0033);

        // Partial-width writes and unmapped addresses
        bus_write(6'h00, 32'h1122_3344, 2'b10);
        bus_write(6'h00, 32'hAABB_CCDD, 2'b00);
        read_chk("byte_wr", 6'h00, 32'h1122_33DD);
        bus_write(6'h00, 32'h5566_7788, 2'b01);
        read_chk("half_wr", 6'h00, 32'h1122_7788);
        bus_write(6'h1C, 32'hFFFF_FFFF, 2'b10);
        read_chk("unmapped_1c", 6'h1C, 32'h0);
        read_chk("unmapped_3c", 6'h3C, 32'h0);

        // Interrupt
        bus_write(6'h18, 32'hFFFF_FF01, 2'b00);
        read_chk("irq_en", 6'h18, 32'h1);
        chk("irq_idle", {31'b0, user_interrupt}, 32'd0);
        do_op(4'd2, 32'h1234_5678, 5'b0);
        chk("irq_set", {31'b0, user_interrupt}, 32'd1);
        read_chk("irq_result", 6'h0C, 32'h1234_5678);
        chk("irq_clr", {31'b0, user_interrupt}, 32'd0);

        // Sticky flags and W1C
        do_op(4'd1, 32'h1, 5'b10001);
        read_chk("fl_r1", 6'h0C, 32'h1);
        do_op(4'd1, 32'h2, 5'b00100);
        read_chk("fl_r2", 6'h0C, 32'h2);
        read_chk("flags_or", 6'h14, 32'h15);
        bus_write(6'h14, 32'h1, 2'b10);
        read_chk("flags_w1c", 6'h14, 32'h14);
        core_resp(32'hDEAD_BEEF, 5'b01000);
        read_chk("stray_flags", 6'h14, 32'h14);
        read_chk("stray_status", 6'h10, 32'h0);
        read_chk("stray_result", 6'h0C, 32'h2);

        // Reset while waiting on the core
        bus_write(6'h08, 32'h5, 2'b10);
        wait_cmd_valid();
        handshake();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, cmd_valid}, 32'd0);
        rst_n = 1'b1;
        read_chk("mid_rst_status", 6'h10, 32'h0);
        read_chk("mid_rst_flags", 6'h14, 32'h0);
        read_chk("mid_rst_irqen", 6'h18, 32'h0);
        core_resp(32'hCAFE_F00D, 5'b11111);
        read_chk("post_rst_status", 6'h10, 32'h0);
        read_chk("post_rst_result", 6'h0C, 32'h0);
        read_chk("post_rst_flags", 6'h14, 32'h0);

`ifdef FPU_FE_TIMEOUT_EN
        // Core never answers
        bus_write(6'h08, 32'h4, 2'b10);
        wait_cmd_valid();
        handshake();
        repeat (270) @(negedge clk);
        read_chk("to_status", 6'h10, 32'h0000_0024);
        read_chk("to_result", 6'h0C, 32'h7FC0_0000);
        read_chk("to_flags", 6'h14, 32'h10);
        core_resp(32'h1234_0000, 5'b0);
        read_chk("to_stray_result", 6'h0C, 32'h7FC0_0000);
        bus_write(6'h10, 32'h20, 2'b10);
        read_chk("to_w1c", 6'h10, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
